// File: rtl/gray_ro_pkg.sv
// -----------------------------------------------------------------------------
// gray_ro_pkg
// Shared definitions for the Gray-code readout chain (serializer and receiver).
//   - GRAY_WIDTH   default data bits per frame
//   - START_BIT / STOP_BIT   line levels that frame a word
//   - rx_state_e   receiver framing FSM states
//   - gray2bin / bin2gray   code conversions, written over GRAY_MAX_W bits;
//     narrower words are zero-extended, which leaves their low bits exact.
// -----------------------------------------------------------------------------
package gray_ro_pkg;

    localparam int GRAY_WIDTH = 8;
    localparam int GRAY_MAX_W = 32;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_e;

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_rx_fifo.sv
// -----------------------------------------------------------------------------
// gray_rx_fifo
// Synchronous FIFO, first-word-fall-through head, no bypass.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, data_i    write request and word; ignored when full unless a pop
//                     happens in the same cycle
//   pop_i             read request; ignored when empty
//   data_o            head word (zero while empty)
//   full_o, empty_o   status flags
// -----------------------------------------------------------------------------
module gray_rx_fifo #(
    parameter int DW    = 12,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          wr_en, rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en = pop_i && !empty_o;
    // A pop frees the slot this same edge, so a full FIFO still accepts the push.
    assign wr_en = push_i && (!full_o || rd_en);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage has no reset; an entry is only visible after it is written,
    // and data_o is masked while empty so nothing stale reaches the port.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/gray_rx_deser.sv
// -----------------------------------------------------------------------------
// gray_rx_deser
// Receiver for the serial Gray-code readout stream: frames the 1-bit line,
// deserializes one Gray word per frame, converts it to binary, tags it with a
// channel index and buffers it in a FIFO behind a valid/ready port.
// Frame: start bit (1), WIDTH Gray bits MSB first, stop bit (0).
// Ports:
//   clk_ext    system clock, rising edge (shared with the serializer)
//   rst_ext    synchronous active-high reset
//   ser_in     serial line, idles low
//   out_data   binary word at the FIFO head (0 when empty)
//   out_ch     channel tag of out_data
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head on out_valid && out_ready
//   frame_err  one-cycle pulse after a stop bit that was not 0
//   overflow   sticky: a word was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module gray_rx_deser
    import gray_ro_pkg::*;
#(
    parameter int WIDTH      = GRAY_WIDTH,
    parameter int N_CH       = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk_ext,
    input  logic                    rst_ext,
    input  logic                    ser_in,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(N_CH)-1:0] out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    frame_err,
    output logic                    overflow
);

    localparam int CHW     = $clog2(N_CH);
    localparam int BCW     = $clog2(WIDTH);
    localparam int ENTRY_W = CHW + WIDTH;

    rx_state_e        state_q, state_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CHW-1:0]   ch_cnt_q, ch_cnt_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;

    logic             push, pop;
    logic             fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] wr_word, rd_word;

    logic [GRAY_MAX_W-1:0] gray_ext, bin_ext;
    logic                  unused_bin_hi;

    // Zero-extend so the shared wide converter yields exact low bits.
    always_comb begin
        gray_ext             = '0;
        gray_ext[WIDTH-1:0]  = shreg_q;
        bin_ext              = gray2bin(gray_ext);
    end
    assign unused_bin_hi = ^bin_ext;

    assign wr_word = {ch_cnt_q, bin_ext[WIDTH-1:0]};
    assign pop     = out_valid && out_ready;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        ch_cnt_d    = ch_cnt_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ser_in == START_BIT) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                shreg_d = {shreg_q[WIDTH-2:0], ser_in};
                if (bit_cnt_q == BCW'(WIDTH - 1)) begin
                    state_d = STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            STOP: begin
                // A bad stop bit returns to IDLE too; that 1 is never reused
                // as a start bit, so a stuck-high line yields back-to-back errors.
                state_d  = IDLE;
                ch_cnt_d = (ch_cnt_q == CHW'(N_CH - 1)) ? '0 : ch_cnt_q + 1'b1;
                if (ser_in == STOP_BIT) begin
                    push = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Overflow only when the word really is dropped: full with no same-cycle pop.
    assign overflow_d = overflow_q || (push && fifo_full && !pop);

    always_ff @(posedge clk_ext) begin
        if (rst_ext) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            ch_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            ch_cnt_q    <= ch_cnt_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    gray_rx_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_ext),
        .rst_i   (rst_ext),
        .push_i  (push),
        .data_i  (wr_word),
        .pop_i   (pop),
        .data_o  (rd_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = rd_word[WIDTH-1:0];
    assign out_ch    = rd_word[ENTRY_W-1:WIDTH];
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_gray_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_gray_rx_deser
// Directed bench for gray_rx_deser (WIDTH=8, N_CH=16, FIFO_DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are read either then
// or on the falling edge. Expected words are queued when a good stop bit is
// driven and are popped by a monitor whenever the DUT hands a word over.
// -----------------------------------------------------------------------------
module tb_gray_rx_deser;

    logic       clk_ext = 1'b0;
    logic       rst_ext = 1'b1;
    logic       ser_in  = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [3:0] out_ch;
    logic       out_valid;
    logic       frame_err;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    logic [11:0] sb[$];       // {ch, binary data}
    logic [3:0]  exp_ch = '0; // channel the next completed frame will carry

    always #5 clk_ext = ~clk_ext;

    gray_rx_deser #(
        .WIDTH      (8),
        .N_CH       (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_ext   (clk_ext),
        .rst_ext   (rst_ext),
        .ser_in    (ser_in),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: binary bit i is the parity of Gray bits [7:i].
    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk_ext);
        #1;
    endtask

    task automatic do_reset();
        ser_in  = 1'b0;
        rst_ext = 1'b1;
        tick();
        tick();
        rst_ext = 1'b0;
        sb.delete();
        exp_ch = '0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_ch",    out_ch,    0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow",  overflow,  0);
    endtask

    // One frame; the expectation is queued unless the stop bit is bad or the
    // caller knows the FIFO will drop the word.
    task automatic send_frame(input logic [7:0] g, input logic stop, input bit drop);
        ser_in = 1'b1;
        tick();
        check("frame_err_after_start", frame_err, 0);
        for (int i = 7; i >= 0; i--) begin
            ser_in = g[i];
            tick();
        end
        ser_in = stop;
        if (stop == 1'b0 && !drop) sb.push_back({exp_ch, g2b(g)});
        tick();
        check("frame_err_after_stop", frame_err, 32'(stop));
        exp_ch = exp_ch + 1'b1;
        ser_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        check("drain_sb_empty", sb.size(), 0);
        tick();
        check("drain_out_valid", out_valid, 0);
    endtask

    // Scoreboard monitor: a handshake seen on the falling edge completes on
    // the next rising edge.
    always @(negedge clk_ext) begin
        if (!rst_ext && out_valid && out_ready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) check("sb_word", {out_ch, out_data}, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bp_tab [5];
        int errs;
        bp_tab[0] = 8'h12; bp_tab[1] = 8'h34; bp_tab[2] = 8'h56;
        bp_tab[3] = 8'h78; bp_tab[4] = 8'h9A;

        // Reset and idle line
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_flags", {out_valid, frame_err, overflow}, 0);
        end

        // Single frame, then a second one while the first is held
        send_frame(8'h0C, 1'b0, 1'b0);
        check("single_valid", out_valid, 1);
        check("single_data",  out_data,  8'h08);
        check("single_ch",    out_ch,    0);
        send_frame(8'hFF, 1'b0, 1'b0);
        check("second_head_stable", {out_ch, out_data}, {4'd0, 8'h08});
        out_ready = 1'b1;
        drain();
        out_ready = 1'b0;

        // Bad stop bit
        do_reset();
        send_frame(8'h01, 1'b1, 1'b0);
        tick();
        check("bad_stop_err_one_cycle", frame_err, 0);
        check("bad_stop_no_push", out_valid, 0);
        send_frame(8'h3C, 1'b0, 1'b0);
        check("after_bad_ch",   out_ch,   1);
        check("after_bad_data", out_data, g2b(8'h3C));
        out_ready = 1'b1;
        drain();

        // Backpressure and overflow
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_frame(bp_tab[k], 1'b0, k == 4);
            if (k == 3) check("bp_no_overflow_yet", overflow, 0);
        end
        check("bp_overflow_set", overflow, 1);
        check("bp_head_kept", {out_ch, out_data}, {4'd0, g2b(bp_tab[0])});
        check("bp_held_count", sb.size(), 4);
        out_ready = 1'b1;
        drain();
        check("bp_overflow_sticky", overflow, 1);

        // Reset in the middle of a frame
        do_reset();
        ser_in = 1'b1;
        tick();
        ser_in = 1'b1; tick();
        ser_in = 1'b0; tick();
        ser_in = 1'b1; tick();
        ser_in = 1'b1; tick();
        do_reset();
        tick();
        check("midrst_no_push", out_valid, 0);
        send_frame(8'h5A, 1'b0, 1'b0);
        drain();

        // Line stuck high: back-to-back errored frames
        do_reset();
        errs = 0;
        ser_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            errs += int'(frame_err);
        end
        ser_in = 1'b0;
        tick();
        check("stuck_high_err_count", errs, 2);
        check("stuck_high_err_clear", frame_err, 0);
        check("stuck_high_no_push", out_valid, 0);
        exp_ch = exp_ch + 4'd2;
        send_frame(8'hC3, 1'b0, 1'b0);
        drain();

        // Channel wrap with back-to-back frames
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            send_frame(8'(k * 37 + 5), 1'b0, 1'b0);
        end
        drain();
        check("wrap_no_overflow", overflow, 0);
        check("wrap_no_frame_err", frame_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
